mips_mem_bridge: RTL and testbench

MIPS_MEM_BRIDGE -- requirements
Module: mips_mem_bridge

---
 rtl/mips_mem_bridge.sv | 197 +++++++++++++++++++
 tb/tb_mips_mem_bridge.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_bridge.sv
// mips_mem_bridge: sequences a multi-cycle MIPS core onto a single
// Avalon-MM style memory port. Each CPU step is an instruction fetch, an
// optional data load, one cpu_clk_enable pulse, and an optional store of the
// values the CPU presented during that pulse.
//
// Bus handshake: a transfer is requested by holding avm_read or avm_write
// high, with a stable avm_address (and avm_writedata for writes), for as many
// cycles as avm_waitrequest is high. The transfer completes in the first
// cycle where the strobe is high and avm_waitrequest is low. Read data is
// taken only in that cycle. At most one strobe is ever high.
module mips_mem_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] stall_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
        STEP   = 3'd3,
        DWRITE = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;

    // DREAD spends its first cycle deciding whether a load is wanted (the
    // CPU sees the freshly latched instruction then); this flag marks that
    // the decision has been taken and the bus read is in progress.
    logic        rd_go_q, rd_go_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] dread_q, dread_d;

    // Store captured in the STEP cycle; the CPU is free to move on afterwards.
    logic        wr_pend_q, wr_pend_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic [31:0] stall_q, stall_d;

    logic        step_ce;

    // State and datapath registers; reset is synchronous and clears all
    // pending work so an interrupted store is never replayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_go_q   <= 1'b0;
            instr_q   <= 32'h0;
            dread_q   <= 32'h0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 32'h0;
            stall_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            rd_go_q   <= rd_go_d;
            instr_q   <= instr_d;
            dread_q   <= dread_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            stall_q   <= stall_d;
        end
    end

    // Next-state logic and bus strobes for the step sequencer.
    always_comb begin
        state_d     = state_q;
        rd_go_d     = rd_go_q;
        instr_d     = instr_q;
        dread_d     = dread_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        avm_address = 32'h0;
        step_ce     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                avm_read    = 1'b1;
                avm_address = instr_address;
                if (!avm_waitrequest) begin
                    instr_d = avm_readdata;
                    rd_go_d = 1'b0;
                    state_d = DREAD;
                end
            end

            DREAD: begin
                if (!rd_go_q) begin
                    // Decision cycle: no bus activity.
                    if (data_read) begin
                        rd_go_d = 1'b1;
                    end else begin
                        state_d = STEP;
                    end
                end else begin
                    avm_read    = 1'b1;
                    avm_address = data_address;
                    if (!avm_waitrequest) begin
                        dread_d = avm_readdata;
                        rd_go_d = 1'b0;
                        state_d = STEP;
                    end
                end
            end

            STEP: begin
                step_ce   = 1'b1;
                wr_pend_d = data_write;
                wr_addr_d = data_address;
                wr_data_d = data_writedata;
                if (data_write) begin
                    state_d = DWRITE;
                end else if (!cpu_active) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end

            DWRITE: begin
                avm_write   = wr_pend_q;
                avm_address = wr_addr_q;
                if (!avm_waitrequest) begin
                    wr_pend_d = 1'b0;
                    state_d   = cpu_active ? FETCH : HALT;
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall counter: every running cycle in which the CPU is not clocked.
    always_comb begin
        stall_d = stall_q;
        if ((state_q != HALT) && !step_ce) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // The CPU is clocked during reset so its own synchronous reset lands.
    assign cpu_clk_enable = reset | step_ce;

    assign instr_readdata = instr_q;
    assign data_readdata  = dread_q;
    assign avm_writedata  = wr_data_q;
    assign avm_byteenable = 4'b1111;
    assign stall_count    = stall_q;
    assign dbg_state      = state_q;

    // Bus strobes are mutually exclusive.
    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        !(avm_read && avm_write));

    // HALT is quiet on both the bus and the CPU clock enable.
    a_halt_quiet: assert property (@(posedge clk) disable iff (reset)
        (state_q == HALT) |-> (!avm_read && !avm_write && !cpu_clk_enable));

    // HALT is only left through reset.
    a_halt_sticky: assert property (@(posedge clk) disable iff (reset)
        (state_q == HALT) |=> (state_q == HALT));

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Testbench for mips_mem_bridge. The bench plays the CPU (one step at a time)
// and a memory with planned wait states. A reference memory and a
// step-timing model predict every bus transfer, latched word and the stall
// counter.
module tb_mips_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_active = 1'b1;
  logic        cpu_clk_enable;
  logic [31:0] instr_address = 32'h0;
  logic [31:0] instr_readdata;
  logic [31:0] data_address = 32'h0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = 32'h0;
  logic [31:0] data_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b1;
  logic [31:0] avm_readdata = 32'h0;
  logic [31:0] stall_count;
  logic [2:0]  dbg_state;

  mips_mem_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_active      (cpu_active),
    .cpu_clk_enable  (cpu_clk_enable),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .stall_count     (stall_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;

  // {is_write, address, data}
  logic [64:0] exp_q[$];
  int          wait_plan[$];

  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          release_cyc = 0;
  int          next_start = 0;
  int          steps_done = 0;
  logic [31:0] last_instr = 32'h0;
  logic [31:0] last_dread = 32'h0;
  bit          pw_valid = 1'b0;
  logic [31:0] pw_addr = 32'h0;
  logic [31:0] pw_data = 32'h0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // ---------------- memory responder and bus monitor ----------------
  bit          in_xfer = 1'b0;
  bit          x_wr = 1'b0;
  logic [31:0] x_addr = 32'h0;
  logic [31:0] x_wdata = 32'h0;
  int          x_cnt = 0;
  logic [64:0] got;
  logic [64:0] want;

  always @(negedge clk) begin
    if (reset) begin
      in_xfer = 1'b0;
      x_cnt = 0;
      avm_waitrequest = 1'b1;
      avm_readdata = $urandom;
    end else begin
      total++;
      if ((avm_read === 1'b1) && (avm_write === 1'b1)) begin
        bad++;
        $display("FAIL both_strobes: read=%b write=%b, required not both", avm_read, avm_write);
      end
      total++;
      if (avm_byteenable !== 4'hf) begin
        bad++;
        $display("FAIL byteenable: got %h, required f", avm_byteenable);
      end
      if ((avm_read === 1'b1) || (avm_write === 1'b1)) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          x_wr = (avm_write === 1'b1);
          x_addr = avm_address;
          x_wdata = avm_writedata;
          if (wait_plan.size() > 0) x_cnt = wait_plan.pop_front();
          else x_cnt = 0;
        end else begin
          total++;
          if ((avm_address !== x_addr) || ((avm_write === 1'b1) !== x_wr) ||
              (x_wr && (avm_writedata !== x_wdata))) begin
            bad++;
            $display("FAIL bus_hold: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                     avm_address, avm_write, avm_writedata, x_addr, x_wr, x_wdata);
          end
        end
        if (x_cnt > 0) begin
          x_cnt--;
          avm_waitrequest = 1'b1;
          avm_readdata = $urandom;
        end else begin
          avm_waitrequest = 1'b0;
          if (x_wr) begin
            bus_mem[x_addr] = x_wdata;
            got = {1'b1, x_addr, x_wdata};
            avm_readdata = $urandom;
          end else begin
            avm_readdata = bus_rd(x_addr);
            got = {1'b0, x_addr, avm_readdata};
          end
          in_xfer = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL bus_unexpected: got transfer %h, required none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL bus_xfer: got %h, required %h", got, want);
            end
          end
        end
      end else begin
        total++;
        if (in_xfer) begin
          bad++;
          $display("FAIL bus_abandon: strobe dropped before completion at addr %h", x_addr);
        end
        in_xfer = 1'b0;
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mark_release();
    release_cyc = cyc;
    next_start = cyc + 1;
    steps_done = 0;
    last_instr = 32'h0;
    last_dread = 32'h0;
    pw_valid = 1'b0;
    exp_q.delete();
    wait_plan.delete();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // One CPU step: present the step's inputs, plan the memory waits, predict
  // the transfers and the cycle of the cpu_clk_enable pulse, then check it.
  task automatic run_step(input logic [31:0] ia, input bit rd, input bit wr,
                          input logic [31:0] da, input logic [31:0] wd, input bit act,
                          input int fw, input int rw, input int ww);
    logic [31:0] exp_instr;
    logic [31:0] exp_data;
    logic [31:0] exp_st;
    int exp_ce;
    int fetch_done;
    int read_done;
    bit seen;
    if (pw_valid) begin
      ref_mem[pw_addr] = pw_data;
      pw_valid = 1'b0;
    end
    instr_address = ia;
    data_read = rd;
    data_write = wr;
    data_address = da;
    data_writedata = wd;
    cpu_active = act;
    exp_instr = ref_rd(ia);
    exp_q.push_back({1'b0, ia, exp_instr});
    wait_plan.push_back(fw);
    exp_data = last_dread;
    if (rd) begin
      exp_data = ref_rd(da);
      exp_q.push_back({1'b0, da, exp_data});
      wait_plan.push_back(rw);
    end
    if (wr) begin
      exp_q.push_back({1'b1, da, wd});
      wait_plan.push_back(ww);
    end
    fetch_done = next_start + fw;
    read_done = fetch_done + 2 + rw;
    exp_ce = next_start + fw + 2 + (rd ? rw + 1 : 0);

    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (cyc <= fetch_done) begin
        total++;
        if (instr_readdata !== last_instr) begin
          bad++;
          $display("FAIL instr_early: cyc %0d got %h, required %h", cyc, instr_readdata, last_instr);
        end
      end
      if (!rd || cyc <= read_done) begin
        total++;
        if (data_readdata !== last_dread) begin
          bad++;
          $display("FAIL dread_early: cyc %0d got %h, required %h", cyc, data_readdata, last_dread);
        end
      end
      if (cpu_clk_enable === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL step_timeout: no cpu_clk_enable pulse, required one at cyc %0d", exp_ce);
    end else begin
      total++;
      if (cyc !== exp_ce) begin
        bad++;
        $display("FAIL step_cycle: pulse at cyc %0d, required %0d", cyc, exp_ce);
      end
      total++;
      if (instr_readdata !== exp_instr) begin
        bad++;
        $display("FAIL instr_word: got %h, required %h", instr_readdata, exp_instr);
      end
      total++;
      if (data_readdata !== exp_data) begin
        bad++;
        $display("FAIL load_word: got %h, required %h", data_readdata, exp_data);
      end
      exp_st = 32'(cyc - release_cyc - steps_done);
      total++;
      if (stall_count !== exp_st) begin
        bad++;
        $display("FAIL stall_count: got %0d, required %0d", stall_count, exp_st);
      end
    end
    steps_done++;
    next_start = cyc + 1 + (wr ? ww + 1 : 0);
    last_instr = exp_instr;
    last_dread = exp_data;
    if (wr) begin
      pw_valid = 1'b1;
      pw_addr = da;
      pw_data = wd;
    end
    @(posedge clk);
    #1;
    // The CPU moves on; a captured store must not follow these.
    data_address = $urandom & 32'hffff_fffc;
    data_writedata = $urandom;
    data_write = 1'($urandom_range(0, 1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (cpu_clk_enable !== 1'b1) begin
      bad++;
      $display("FAIL reset_ce: got %b, required 1", cpu_clk_enable);
    end
    total++;
    if ((avm_read !== 1'b0) || (avm_write !== 1'b0)) begin
      bad++;
      $display("FAIL reset_strobes: read=%b write=%b, required 0 0", avm_read, avm_write);
    end
    total++;
    if ((instr_readdata !== 32'h0) || (data_readdata !== 32'h0) || (stall_count !== 32'h0)) begin
      bad++;
      $display("FAIL reset_regs: instr=%h data=%h stall=%h, required all 0",
               instr_readdata, data_readdata, stall_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mark_release();
    @(negedge clk);
    total++;
    if ((cpu_clk_enable !== 1'b0) || (avm_read !== 1'b0) || (stall_count !== 32'h0)) begin
      bad++;
      $display("FAIL idle_cycle: ce=%b read=%b stall=%h, required 0 0 0",
               cpu_clk_enable, avm_read, stall_count);
    end
  endtask

  task automatic test_boot();
    preload(32'hbfc0_0000, 32'h2402_0005);
    run_step(32'hbfc0_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_fetch_stall();
    run_step(32'hbfc0_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5, 0, 0);
  endtask

  task automatic test_load();
    preload(32'h0000_1000, 32'hdead_beef);
    run_step(32'hbfc0_0008, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 0, 1, 0);
  endtask

  task automatic test_store();
    run_step(32'hbfc0_000c, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1, 0, 0, 1);
    @(negedge clk);
    total++;
    if ((avm_write !== 1'b1) || (avm_read !== 1'b0) || (avm_address !== 32'h0000_2000) ||
        (avm_writedata !== 32'h1234_5678) || (avm_byteenable !== 4'hf)) begin
      bad++;
      $display("FAIL store_bus: wr=%b rd=%b addr=%h data=%h be=%h, required 1 0 00002000 12345678 f",
               avm_write, avm_read, avm_address, avm_writedata, avm_byteenable);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_step(32'h0040_0000 + 32'(i * 4), 1'b1, 1'b1, 32'h0000_3000 + 32'(i * 4),
               $urandom, 1'b1, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    logic [31:0] ia;
    logic [31:0] da;
    for (int i = 0; i < 30; i++) begin
      ia = 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
      da = 32'h0000_0100 + (32'($urandom_range(0, 15)) << 2);
      run_step(ia, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom, 1'b1,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_write();
    run_step(32'h0040_0100, 1'b0, 1'b1, 32'h0000_4000, 32'hcafe_f00d, 1'b1, 0, 0, 8);
    @(negedge clk);
    total++;
    if (avm_write !== 1'b1) begin
      bad++;
      $display("FAIL midwr_stalled: avm_write=%b, required 1", avm_write);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_clk_enable !== 1'b1) begin
      bad++;
      $display("FAIL midwr_reset_ce: got %b, required 1", cpu_clk_enable);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mark_release();
    @(negedge clk);
    total++;
    if ((avm_write !== 1'b0) || (avm_read !== 1'b0)) begin
      bad++;
      $display("FAIL midwr_drop: write=%b read=%b, required 0 0", avm_write, avm_read);
    end
    total++;
    if ((instr_readdata !== 32'h0) || (data_readdata !== 32'h0) || (stall_count !== 32'h0)) begin
      bad++;
      $display("FAIL midwr_regs: instr=%h data=%h stall=%h, required all 0",
               instr_readdata, data_readdata, stall_count);
    end
    // Restart from the CPU's address, then read back the aborted location.
    run_step(32'h0040_0200, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 1, 0, 0);
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    logic [31:0] held_instr;
    run_step(32'h0040_0300, 1'b0, 1'b1, 32'h0000_5000, 32'h0bad_cafe, 1'b0, 0, 0, 2);
    frozen = 32'(next_start - release_cyc - steps_done);
    held_instr = last_instr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc >= next_start) begin
        total++;
        if ((avm_read !== 1'b0) || (avm_write !== 1'b0) || (cpu_clk_enable !== 1'b0)) begin
          bad++;
          $display("FAIL halt_quiet: cyc %0d read=%b write=%b ce=%b, required 0 0 0",
                   cyc, avm_read, avm_write, cpu_clk_enable);
        end
        total++;
        if (stall_count !== frozen) begin
          bad++;
          $display("FAIL halt_stall: got %0d, required %0d", stall_count, frozen);
        end
        total++;
        if (instr_readdata !== held_instr) begin
          bad++;
          $display("FAIL halt_instr: got %h, required %h", instr_readdata, held_instr);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL halt_pending: %0d expected transfers never seen, required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_boot();
    test_fetch_stall();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
